// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester shared ALU with a one-deep registered result
// Optional feature macro: ALU_ARB_FIXED_PRIO_EN (requester 0 always wins contention)
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqK_valid / reqK_ready     requester K handshake (K = 0, 1)
//   reqK_op, reqK_a, reqK_b     operation code and operands of requester K
//   rsp_valid / rsp_ready       result handshake
//   rsp_id, rsp_result, rsp_zero  owner, value and zero flag of the held result
module alu_share_arbiter #(
   parameter int RR_INIT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic        rsp_zero
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]  state_q;
   logic        can_grant;
   logic        pick1;
   logic        grant;
   logic [3:0]  sel_op;
   logic [31:0] sel_a;
   logic [31:0] sel_b;
   logic [31:0] alu_res;

   // The result register can take a new value when empty or when it is
   // being drained this very cycle. rst_n gates it so no handshake is
   // offered while reset is held.
   assign can_grant = rst_n && ((state_q == EMPTY) || rsp_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign pick1 = req1_valid && !req0_valid;
`else
   logic last_q;

   // Under contention requester 1 wins only if requester 0 was granted last.
   assign pick1 = req1_valid && (!req0_valid || !last_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= RR_INIT[0];
      end else if (grant) begin
         last_q <= pick1;
      end
   end
`endif

   assign req0_ready = can_grant && req0_valid && !pick1;
   assign req1_ready = can_grant && pick1;
   assign grant      = req0_ready || req1_ready;

   assign sel_op = pick1 ? req1_op : req0_op;
   assign sel_a  = pick1 ? req1_a  : req0_a;
   assign sel_b  = pick1 ? req1_b  : req0_b;

   always_comb begin
      alu_res = 32'd0;
      case (sel_op)
         4'b0000: alu_res = sel_a + sel_b;
         4'b0001: alu_res = sel_a - sel_b;
         4'b0010: alu_res = {31'd0, $signed(sel_a) < $signed(sel_b)};
         4'b0011: alu_res = {31'd0, sel_a < sel_b};
         4'b0100: alu_res = sel_a & sel_b;
         4'b0101: alu_res = sel_a | sel_b;
         4'b0110: alu_res = sel_a ^ sel_b;
         default: alu_res = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         rsp_id     <= 1'b0;
         rsp_result <= 32'd0;
         rsp_zero   <= 1'b0;
      end else if (grant) begin
         state_q    <= FULL;
         rsp_id     <= pick1;
         rsp_result <= alu_res;
         rsp_zero   <= (alu_res == 32'd0);
      end else if (rsp_ready) begin
         // Payload registers keep their last value; only validity drops.
         state_q <= EMPTY;
      end
   end

   assign rsp_valid = (state_q == FULL);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req0_ready;
   logic [3:0]  req0_op;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready;
   logic [3:0]  req1_op;
   logic [31:0] req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
   logic [31:0] rsp_result;

   int total = 0;
   int bad   = 0;

   // reference model state
   bit          m_full;
   bit          m_id;
   bit          m_last;
   logic [31:0] m_res;
   int          last_win;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[14];
   int   order_got[4];
   int   order_exp[4];

   alu_share_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         // signed order: differing signs decide by the sign of a, else unsigned order
         4'd2: return ((a[31] != b[31]) ? a[31] : (a < b)) ? 32'd1 : 32'd0;
         4'd3: return (a < b) ? 32'd1 : 32'd0;
         4'd4: return a & b;
         4'd5: return a | b;
         4'd6: return a ^ b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_full = 0;
      m_id   = 0;
      m_last = 1'b1;   // RR_INIT default
      m_res  = 32'd0;
   endtask

   // Entered just after a rising edge with inputs already driven; checks the
   // grant mid-cycle, then the response just after the next edge.
   task automatic run_cycle();
      bit          g, w;
      logic [31:0] res;
      g = 0;
      w = 0;
      #3;
      if (!m_full || rsp_ready) begin
         if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = (m_last == 1'b0);
`endif
            g = 1;
         end else if (req0_valid) begin
            g = 1; w = 0;
         end else if (req1_valid) begin
            g = 1; w = 1;
         end
      end
      chk("req0_ready", req0_ready, g && !w);
      chk("req1_ready", req1_ready, g && w);
      res = w ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
      last_win = g ? int'(w) : -1;
      @(posedge clk);
      if (g) begin
         m_full = 1; m_id = w; m_res = res; m_last = w;
      end else if (rsp_ready) begin
         m_full = 0;
      end
      #1;
      chk("rsp_valid", rsp_valid, m_full);
      if (m_full) begin
         chk("rsp_id", rsp_id, m_id);
         chk("rsp_result", rsp_result, m_res);
         chk("rsp_zero", rsp_zero, m_res == 32'd0);
      end
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
      req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
      rsp_ready  = 1;
   endtask

   // Reset pulse spanning one edge with both requesters valid; returns just
   // after an edge with rst_n released mid-cycle.
   task automatic apply_reset();
      @(posedge clk);
      #1;
      rst_n = 0;
      req0_valid = 1; req1_valid = 1;
      #2;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      @(posedge clk);
      #1;
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_zero", rsp_zero, 0);
      chk("rst_ready_hold", req0_ready | req1_ready, 0);
      rst_n = 1;
      idle_inputs();
      model_reset();
   endtask

   initial begin
      tbl[0]  = '{4'b0000, 32'd5,        32'd7,        32'd12};
      tbl[1]  = '{4'b0000, 32'hFFFFFFFF, 32'd1,        32'd0};
      tbl[2]  = '{4'b0001, 32'd3,        32'd3,        32'd0};
      tbl[3]  = '{4'b0001, 32'd0,        32'd1,        32'hFFFFFFFF};
      tbl[4]  = '{4'b0010, 32'h80000000, 32'h7FFFFFFF, 32'd1};
      tbl[5]  = '{4'b0011, 32'h80000000, 32'h7FFFFFFF, 32'd0};
      tbl[6]  = '{4'b0010, 32'hFFFFFFFF, 32'd1,        32'd1};
      tbl[7]  = '{4'b0011, 32'hFFFFFFFF, 32'd1,        32'd0};
      tbl[8]  = '{4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
      tbl[9]  = '{4'b0101, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF};
      tbl[10] = '{4'b0110, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555};
      tbl[11] = '{4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
      tbl[12] = '{4'b0111, 32'd1,        32'd2,        32'd0};
      tbl[13] = '{4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'd0};

      rst_n = 0;
      idle_inputs();
      model_reset();
      apply_reset();

      // single-requester op table, result register drained every cycle
      for (int i = 0; i < 14; i++) begin
         req0_valid = 1;
         req0_op = tbl[i].op; req0_a = tbl[i].a; req0_b = tbl[i].b;
         rsp_ready = 1;
         run_cycle();
         chk("tbl_result", rsp_result, tbl[i].exp);
         chk("tbl_zero", rsp_zero, tbl[i].exp == 32'd0);
         chk("tbl_id", rsp_id, 0);
      end
      idle_inputs();
      run_cycle();

      // contention order from reset
      apply_reset();
`ifdef ALU_ARB_FIXED_PRIO_EN
      order_exp = '{0, 0, 0, 0};
`else
      order_exp = '{0, 1, 0, 1};
`endif
      for (int i = 0; i < 4; i++) begin
         req0_valid = 1; req0_op = 4'd0; req0_a = 32'd10 + i; req0_b = 32'd1;
         req1_valid = 1; req1_op = 4'd0; req1_a = 32'd20 + i; req1_b = 32'd1;
         rsp_ready = 1;
         run_cycle();
         order_got[i] = int'(rsp_id);
         chk("rr_order", order_got[i], order_exp[i]);
      end
      idle_inputs();
      run_cycle();

      // back-pressure: SUB 3-3 from req1 held for three stalled cycles
      apply_reset();
      req1_valid = 1; req1_op = 4'b0001; req1_a = 32'd3; req1_b = 32'd3;
      run_cycle();
      req0_valid = 1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd1;
      req1_op = 4'd0;
      rsp_ready = 0;
      for (int i = 0; i < 3; i++) begin
         run_cycle();
         chk("stall_ready", req0_ready | req1_ready, 0);
         chk("stall_result", rsp_result, 0);
         chk("stall_zero", rsp_zero, 1);
         chk("stall_id", rsp_id, 1);
      end

      // drain and refill with SLT, then SLTU of the same operands
      rsp_ready = 1;
      req1_valid = 0;
      req0_op = 4'b0010; req0_a = 32'h80000000; req0_b = 32'h7FFFFFFF;
      run_cycle();
      chk("refill_slt", rsp_result, 1);
      chk("refill_slt_valid", rsp_valid, 1);
      req0_op = 4'b0011;
      run_cycle();
      chk("refill_sltu", rsp_result, 0);

      // asynchronous reset while FULL, then immediate grant after release
      rsp_ready = 0;
      req0_op = 4'd0; req0_a = 32'd100; req0_b = 32'd23;
      run_cycle();
      chk("pre_rst_full", rsp_valid, 1);
      #2;
      rst_n = 0;
      #1;
      chk("async_drop", rsp_valid, 0);
      chk("async_ready", req0_ready, 0);
      #2;
      rst_n = 1;
      model_reset();
      idle_inputs();
      @(posedge clk);
      #1;
      chk("no_stale_rsp", rsp_valid, 0);
      req0_valid = 1; req0_op = 4'd0; req0_a = 32'd40; req0_b = 32'd2;
      run_cycle();
      chk("post_rst_grant", rsp_result, 42);
      idle_inputs();
      run_cycle();

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 3) != 0);
         req0_op = 4'($urandom_range(0, 15));
         req1_op = 4'($urandom_range(0, 15));
         req0_a = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
         req0_b = ($urandom_range(0, 4) == 0) ? req0_a : $urandom;
         req1_a = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom;
         req1_b = ($urandom_range(0, 4) == 0) ? req1_a : $urandom;
         rsp_ready = ($urandom_range(0, 9) < 7);
         run_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
